// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, header address field,
// port-address constants and the control FSM state encoding.
package router_pkg;

  localparam int unsigned DataWidth = 8;

  // Header bits [1:0] select the destination port.
  localparam int unsigned AddrMsb = 1;
  localparam int unsigned AddrLsb = 0;

  localparam logic [1:0] AddrPort0 = 2'b00;
  localparam logic [1:0] AddrPort1 = 2'b01;
  localparam logic [1:0] AddrPort2 = 2'b10;

  // Control FSM state encoding, shared with the control FSM.
  typedef enum logic [2:0] {
    StDecodeAddress    = 3'd0,
    StLoadFirstData    = 3'd1,
    StLoadData         = 3'd2,
    StWaitTillEmpty    = 3'd3,
    StFifoFullState    = 3'd4,
    StLoadAfterFull    = 3'd5,
    StLoadParity       = 3'd6,
    StCheckParityError = 3'd7
  } router_state_e;

  // Destination address carried in a header byte.
  function automatic logic [1:0] header_addr(input logic [DataWidth-1:0] header);
    return header[AddrMsb:AddrLsb];
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Bus between the router control/source side and the router_reg datapath.
// master: drives source byte, full flag and FSM state decodes; receives
//         FIFO write data and status flags.
// slave:  the register stage itself.
interface router_reg_if
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router.
// Latches the header byte, stages payload onto the FIFO write bus (dout),
// parks a byte in hold_byte while the FIFO is full, accumulates XOR parity
// and compares it against the trailing parity byte.
// Ports:
//   clock  - rising-edge clock
//   resetn - synchronous active-low reset
//   bus    - router_reg_if.slave: source byte/valid, fifo_full, FSM decodes in;
//            dout, parity_done, low_pkt_valid, err out (all registered)
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
) (
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
  logic [DATA_WIDTH-1:0] hold_byte_q,   hold_byte_d;
  logic [DATA_WIDTH-1:0] int_parity_q,  int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q,  pkt_parity_d;
  logic [DATA_WIDTH-1:0] dout_q,        dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  err_q,         err_d;

  always_comb begin
    header_byte_d   = header_byte_q;
    hold_byte_d     = hold_byte_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (bus.detect_add) begin
      parity_done_d   = 1'b0;
      low_pkt_valid_d = 1'b0;
      if (bus.pkt_valid) begin
        header_byte_d = bus.data_in;
        int_parity_d  = bus.data_in;
        err_d         = 1'b0;
      end
    end else if (bus.lfd_state) begin
      dout_d = header_byte_q;
    end else if (bus.ld_state) begin
      if (bus.fifo_full) begin
        hold_byte_d = bus.data_in;
      end else begin
        dout_d = bus.data_in;
      end
      if (bus.pkt_valid) begin
        // Accumulated once per ld cycle even when the byte is parked.
        int_parity_d = int_parity_q ^ bus.data_in;
      end else begin
        pkt_parity_d    = bus.data_in;
        low_pkt_valid_d = 1'b1;
        if (!bus.fifo_full) begin
          parity_done_d = 1'b1;
        end
      end
    end else if (bus.laf_state) begin
      dout_d = hold_byte_q;
      // A parked parity byte is only now staged to the FIFO.
      if (low_pkt_valid_q) begin
        parity_done_d = 1'b1;
      end
    end else if (bus.rst_int_reg) begin
      err_d           = (int_parity_q != pkt_parity_q);
      low_pkt_valid_d = 1'b0;
    end
    // full_state and no-decode cycles fall through and hold everything.
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte_q   <= '0;
      hold_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_byte_q   <= header_byte_d;
      hold_byte_q     <= hold_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed, table-driven bench for router_reg. Each vector is one clock
// cycle: inputs are driven, the edge is taken, and the registered outputs
// are compared 1 time unit later against hand-computed values.
module tb_router_reg;

  logic clock;
  logic resetn;

  router_reg_if #(.DATA_WIDTH(8)) bus ();

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // State decode one-hots: {detect_add, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] SNone = 6'b000000;
  localparam logic [5:0] SDa   = 6'b100000;
  localparam logic [5:0] SLfd  = 6'b010000;
  localparam logic [5:0] SLd   = 6'b001000;
  localparam logic [5:0] SLaf  = 6'b000100;
  localparam logic [5:0] SFull = 6'b000010;
  localparam logic [5:0] SRst  = 6'b000001;

  typedef struct {
    logic       rstn;
    logic       pv;
    logic [7:0] din;
    logic       ff;
    logic [5:0] st;
    logic [7:0] e_dout;
    logic       e_pd;
    logic       e_lpv;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input logic rstn, input logic pv, input logic [7:0] din,
                              input logic ff, input logic [5:0] st, input logic [7:0] e_dout,
                              input logic e_pd, input logic e_lpv, input logic e_err);
    vec_t v;
    v.rstn = rstn; v.pv = pv; v.din = din; v.ff = ff; v.st = st;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    resetn          = v.rstn;
    bus.pkt_valid   = v.pv;
    bus.data_in     = v.din;
    bus.fifo_full   = v.ff;
    bus.detect_add  = v.st[5];
    bus.lfd_state   = v.st[4];
    bus.ld_state    = v.st[3];
    bus.laf_state   = v.st[2];
    bus.full_state  = v.st[1];
    bus.rst_int_reg = v.st[0];
    @(posedge clock);
    #1;
    n_vec++;
    if (bus.dout !== v.e_dout || bus.parity_done !== v.e_pd ||
        bus.low_pkt_valid !== v.e_lpv || bus.err !== v.e_err) begin
      n_bad++;
      $display("FAIL %s vec %0d: got dout=%h pd=%b lpv=%b err=%b, want dout=%h pd=%b lpv=%b err=%b",
               name, n_vec, bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err,
               v.e_dout, v.e_pd, v.e_lpv, v.e_err);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // rstn, pv, din, ff, state, -> dout, pd, lpv, err
    vecs.push_back(mk(0, 0, 8'h00, 0, SNone, 8'h00, 0, 0, 0));  // reset state
    // Good packet 05 A3 A6
    vecs.push_back(mk(1, 1, 8'h05, 0, SDa,   8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLfd,  8'h05, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLd,   8'hA3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 0, SLd,   8'hA6, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 0, SRst,  8'hA6, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, SDa,   8'hA6, 0, 0, 0));
    // Bad parity A7 -> err, cleared by next header 04
    vecs.push_back(mk(1, 1, 8'h05, 0, SDa,   8'hA6, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLfd,  8'h05, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLd,   8'hA3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA7, 0, SLd,   8'hA7, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA7, 0, SRst,  8'hA7, 1, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, SDa,   8'hA7, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h04, 0, SDa,   8'hA7, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, SLfd,  8'h04, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, SLd,   8'h11, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h15, 0, SLd,   8'h15, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h15, 0, SRst,  8'h15, 1, 0, 0));
    // Full on payload byte 22: 0A 11 22 39
    vecs.push_back(mk(1, 1, 8'h0A, 0, SDa,   8'h15, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, SLfd,  8'h0A, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, SLd,   8'h11, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 1, SLd,   8'h11, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 1, SFull, 8'h11, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 0, SFull, 8'h11, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 0, SLaf,  8'h22, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h39, 0, SLd,   8'h39, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h39, 0, SRst,  8'h39, 1, 0, 0));
    // Full on parity byte: 05 A3 A6
    vecs.push_back(mk(1, 1, 8'h05, 0, SDa,   8'h39, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLfd,  8'h05, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA3, 0, SLd,   8'hA3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 1, SLd,   8'hA3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 1, SFull, 8'hA3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 0, SLaf,  8'hA6, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA6, 0, SRst,  8'hA6, 1, 0, 0));

    foreach (vecs[i]) step(vecs[i], "table");

    // Reset with err/parity_done set
    step(mk(1, 1, 8'h0A, 0, SDa,   8'hA6, 0, 0, 0), "rst_err_hdr");
    step(mk(1, 1, 8'h11, 0, SLfd,  8'h0A, 0, 0, 0), "rst_err_lfd");
    step(mk(1, 1, 8'h11, 0, SLd,   8'h11, 0, 0, 0), "rst_err_ld");
    step(mk(1, 0, 8'h5A, 0, SLd,   8'h5A, 1, 1, 0), "rst_err_par");
    step(mk(1, 0, 8'h5A, 0, SRst,  8'h5A, 1, 0, 1), "rst_err_chk");
    step(mk(0, 0, 8'h00, 0, SNone, 8'h00, 0, 0, 0), "rst_err_clear");

    // Reset mid-payload, then a clean packet 01 55 54
    step(mk(1, 1, 8'h0A, 0, SDa,   8'h00, 0, 0, 0), "mid_hdr");
    step(mk(1, 1, 8'h11, 0, SLfd,  8'h0A, 0, 0, 0), "mid_lfd");
    step(mk(1, 1, 8'h11, 0, SLd,   8'h11, 0, 0, 0), "mid_ld");
    step(mk(0, 1, 8'h22, 0, SLd,   8'h00, 0, 0, 0), "mid_reset");
    step(mk(1, 1, 8'h01, 0, SDa,   8'h00, 0, 0, 0), "post_hdr");
    step(mk(1, 1, 8'h55, 0, SLfd,  8'h01, 0, 0, 0), "post_lfd");
    step(mk(1, 1, 8'h55, 0, SLd,   8'h55, 0, 0, 0), "post_ld");
    step(mk(1, 0, 8'h54, 0, SLd,   8'h54, 1, 1, 0), "post_par");
    step(mk(1, 0, 8'h54, 0, SRst,  8'h54, 1, 0, 0), "post_chk");

    // detect_add with pkt_valid low must not touch header_byte or err
    step(mk(1, 1, 8'h02, 0, SDa,   8'h54, 0, 0, 0), "da_hdr");
    step(mk(1, 1, 8'h33, 0, SLfd,  8'h02, 0, 0, 0), "da_lfd");
    step(mk(1, 1, 8'h33, 0, SLd,   8'h33, 0, 0, 0), "da_ld");
    step(mk(1, 0, 8'h00, 0, SLd,   8'h00, 1, 1, 0), "da_par");
    step(mk(1, 0, 8'h00, 0, SRst,  8'h00, 1, 0, 1), "da_chk");
    for (int k = 0; k < 5; k++) begin
      step(mk(1, 0, 8'hFF, 0, SDa, 8'h00, 0, 0, 1), "da_idle");
    end
    // Header still 02, not FF
    step(mk(1, 0, 8'hFF, 0, SLfd,  8'h02, 0, 0, 1), "da_header_kept");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
